// File: rtl/fan_packet_tx_if.sv
// fan_packet_tx_if: request/status bundle for fan_packet_tx; FAN_TX_ABORT_EN adds abort/aborted.
interface fan_packet_tx_if #(
  parameter int ID_WIDTH = 4,
  parameter int PAYLOAD_WIDTH = 7,
  parameter int REPEAT_WIDTH = 4
);
  logic [ID_WIDTH-1:0] id;
  logic [PAYLOAD_WIDTH-1:0] payload;
  logic [REPEAT_WIDTH-1:0] repeats;
  logic start;
  logic busy;
  logic done;
  logic out;
`ifdef FAN_TX_ABORT_EN
  logic abort;
  logic aborted;
  modport master (output id, payload, repeats, start, abort, input busy, done, out, aborted);
  modport slave (input id, payload, repeats, start, abort, output busy, done, out, aborted);
`else
  modport master (output id, payload, repeats, start, input busy, done, out);
  modport slave (input id, payload, repeats, start, output busy, done, out);
`endif
endinterface

// File: rtl/fan_packet_tx.sv
// fan_packet_tx: OOK pulse-width packet transmitter with repeats and inter-frame gaps.
// Define FAN_TX_ABORT_EN to add the abort input and aborted pulse.
module fan_packet_tx #(
  parameter int CLK_DIV = 2203,
  parameter int ID_WIDTH = 4,
  parameter int PAYLOAD_WIDTH = 7,
  parameter int LEAD_BITS = 2,
  parameter int GAP_SLOTS = 30,
  parameter int REPEAT_WIDTH = 4
) (
  input logic ref_clk,
  input logic reset,
  fan_packet_tx_if.slave bus
);
  localparam int NBITS = LEAD_BITS + ID_WIDTH + PAYLOAD_WIDTH;
  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = $clog2(NBITS + 1);
  localparam int GW = $clog2(GAP_SLOTS + 1);
  typedef enum logic [1:0] {IDLE, FRAME, GAP} state_t;
  state_t state;
  logic [NBITS-1:0] frame_q;
  logic [NBITS-1:0] cur;
  logic [REPEAT_WIDTH-1:0] frames;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [GW-1:0] gap;
  logic [1:0] phase;
  logic out_q;
  logic busy_q;
  logic done_q;
  assign cur = frame_q >> idx;
  assign bus.out = out_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
`ifdef FAN_TX_ABORT_EN
  logic aborted_q;
  assign bus.aborted = aborted_q;
`endif
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      state <= IDLE;
      frame_q <= '0;
      frames <= '0;
      cnt <= '0;
      idx <= '0;
      gap <= '0;
      phase <= '0;
      out_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef FAN_TX_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef FAN_TX_ABORT_EN
      aborted_q <= 1'b0;
`endif
      if (state == IDLE) begin
        if (bus.start) begin
          frame_q <= NBITS'({bus.payload, bus.id}) << LEAD_BITS;
          frames <= bus.repeats;
          state <= FRAME;
          busy_q <= 1'b1;
          out_q <= 1'b0;
          cnt <= CW'(CLK_DIV - 1);
          phase <= 2'd0;
          idx <= '0;
        end
      end
`ifdef FAN_TX_ABORT_EN
      else if (bus.abort) begin
        state <= IDLE;
        busy_q <= 1'b0;
        out_q <= 1'b0;
        aborted_q <= 1'b1;
      end
`endif
      else if (cnt != '0) cnt <= cnt - 1'b1;
      else begin
        cnt <= CW'(CLK_DIV - 1);
        if (state == FRAME) begin
          // out is loaded with the level of the slot about to begin
          phase <= phase == 2'd2 ? 2'd0 : phase + 2'd1;
          out_q <= phase == 2'd0 ? cur[0] : phase == 2'd1;
          if (phase == 2'd2) begin
            idx <= idx + 1'b1;
            if (idx == IW'(NBITS - 1)) begin
              state <= GAP;
              gap <= GW'(GAP_SLOTS - 1);
            end
          end
        end else if (gap != '0) gap <= gap - 1'b1;
        else if (frames == '0) begin
          state <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          frames <= frames - 1'b1;
          state <= FRAME;
          idx <= '0;
          phase <= 2'd0;
        end
      end
    end
  end
endmodule

// File: tb/tb_fan_packet_tx.sv
// tb_fan_packet_tx: checks two fan_packet_tx builds against a slot-level waveform model.
module tb_fan_packet_tx;
  logic ref_clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic sel_v = 1'b0;
  logic [15:0] id_v = '0;
  logic [15:0] pl_v = '0;
  logic [3:0] rep_v = '0;
  int checks = 0;
  int errors = 0;
  always #5 ref_clk = ~ref_clk;
  fan_packet_tx_if #(.ID_WIDTH(4), .PAYLOAD_WIDTH(7), .REPEAT_WIDTH(4)) ia ();
  fan_packet_tx_if #(.ID_WIDTH(8), .PAYLOAD_WIDTH(12), .REPEAT_WIDTH(4)) ib ();
  assign ia.id = id_v[3:0];
  assign ia.payload = pl_v[6:0];
  assign ia.repeats = rep_v;
  assign ia.start = start && !sel_v;
  assign ib.id = id_v[7:0];
  assign ib.payload = pl_v[11:0];
  assign ib.repeats = rep_v;
  assign ib.start = start && sel_v;
`ifdef FAN_TX_ABORT_EN
  logic abort = 1'b0;
  assign ia.abort = abort;
  assign ib.abort = 1'b0;
`endif
  fan_packet_tx #(.CLK_DIV(4), .ID_WIDTH(4), .PAYLOAD_WIDTH(7), .LEAD_BITS(2), .GAP_SLOTS(30), .REPEAT_WIDTH(4))
    dut_a (.ref_clk(ref_clk), .reset(reset), .bus(ia));
  fan_packet_tx #(.CLK_DIV(2), .ID_WIDTH(8), .PAYLOAD_WIDTH(12), .LEAD_BITS(0), .GAP_SLOTS(30), .REPEAT_WIDTH(4))
    dut_b (.ref_clk(ref_clk), .reset(reset), .bus(ib));
  wire o_out = sel_v ? ib.out : ia.out;
  wire o_busy = sel_v ? ib.busy : ia.busy;
  wire o_done = sel_v ? ib.done : ia.done;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Level of out k cycles after acceptance, from the symbol/gap rules
  function automatic logic exp_out(input int k, input int cd, input int lead, input int iw, input int nb,
                                   input logic [15:0] idv, input logic [15:0] plv);
    int s, b;
    s = (k / cd) % (3 * nb + 30);
    b = s / 3;
    if (s >= 3 * nb || s % 3 == 0) return 1'b0;
    if (s % 3 == 2) return 1'b1;
    return b < lead ? 1'b0 : b < lead + iw ? idv[b-lead] : plv[b-lead-iw];
  endfunction
  // mode 0 plain, 1 disturb inputs and re-pulse start, 2 raise start before done
  task automatic xfer(input logic sel, input logic [15:0] idv, input logic [15:0] plv, input int rep,
                      input int mode, input string tag);
    int cd, lead, iw, nb, total, bad, first_k;
    logic fo, fe;
    cd = sel ? 2 : 4;
    lead = sel ? 0 : 2;
    iw = sel ? 8 : 4;
    nb = sel ? 20 : 13;
    total = (rep + 1) * (3 * nb + 30) * cd;
    bad = 0;
    first_k = 0;
    fo = 1'b0;
    sel_v = sel;
    id_v = idv;
    pl_v = plv;
    rep_v = 4'(rep);
    start = 1'b1;
    @(negedge ref_clk);
    start = 1'b0;
    for (int k = 0; k < total; k++) begin
      if (k > 0) @(negedge ref_clk);
      fe = exp_out(k, cd, lead, iw, nb, idv, plv);
      if (o_out !== fe || o_busy !== 1'b1 || o_done !== 1'b0) begin
        if (bad == 0) begin
          first_k = k;
          fo = o_out;
        end
        bad++;
      end
      if (mode == 1 && (k == 10 || k == 200)) begin
        start = 1'b1;
        id_v = 16'($urandom);
        pl_v = 16'($urandom);
        rep_v = 4'($urandom);
      end
      if (mode == 1 && (k == 11 || k == 201)) start = 1'b0;
      if (mode == 2 && k == total - 1) start = 1'b1;
    end
    if (bad != 0) $display("%s: first bad cycle %0d out %b model %b", tag, first_k, fo, exp_out(first_k, cd, lead, iw, nb, idv, plv));
    chk({tag, " wave"}, 32'(bad), 32'd0);
    @(negedge ref_clk);
    chk({tag, " busy end"}, 32'(o_busy), 32'd0);
    chk({tag, " done"}, 32'(o_done), 32'd1);
  endtask
  initial begin
    int hits;
    repeat (3) @(negedge ref_clk);
    chk("rst busy a", 32'(ia.busy), 32'd0);
    chk("rst out a", 32'(ia.out), 32'd0);
    chk("rst done a", 32'(ia.done), 32'd0);
    chk("rst busy b", 32'(ib.busy), 32'd0);
    reset = 1'b0;
    @(negedge ref_clk);
    xfer(1'b0, 16'b1010, 16'b1001111, 0, 0, "t1");
    @(negedge ref_clk);
    chk("t1 done once", 32'(o_done), 32'd0);
    xfer(1'b0, 16'b1010, 16'b1001111, 2, 1, "t2");
    @(negedge ref_clk);
    chk("t2 done once", 32'(o_done), 32'd0);
    xfer(1'b0, 16'($urandom), 16'($urandom), 0, 2, "t3 held");
    xfer(1'b0, 16'($urandom), 16'($urandom), 1, 0, "t3 retrig");
    @(negedge ref_clk);
    chk("t3 done once", 32'(o_done), 32'd0);
    sel_v = 1'b0;
    id_v = 16'b1010;
    pl_v = 16'b1001111;
    rep_v = 4'd0;
    start = 1'b1;
    @(negedge ref_clk);
    start = 1'b0;
    repeat (64) @(negedge ref_clk);
    chk("t4 bit5 ph1 out", 32'(ia.out), 32'd1);
    reset = 1'b1;
    @(negedge ref_clk);
    reset = 1'b0;
    chk("t4 reset out", 32'(ia.out), 32'd0);
    chk("t4 reset busy", 32'(ia.busy), 32'd0);
    hits = 0;
    repeat (300) begin
      @(negedge ref_clk);
      if (ia.done || ia.busy) hits++;
    end
    chk("t4 no done", 32'(hits), 32'd0);
    xfer(1'b0, 16'b1010, 16'b1001111, 0, 0, "t4 after");
    xfer(1'b1, 16'h00A5, 16'h03C1, 0, 0, "t5");
    @(negedge ref_clk);
    chk("t5 done once", 32'(o_done), 32'd0);
    for (int i = 0; i < 4; i++) xfer(1'b0, 16'($urandom), 16'($urandom), int'($urandom_range(0, 1)), 0, "rnd a");
    for (int i = 0; i < 2; i++) xfer(1'b1, 16'($urandom), 16'($urandom), int'($urandom_range(0, 1)), 0, "rnd b");
`ifdef FAN_TX_ABORT_EN
    @(negedge ref_clk);
    sel_v = 1'b0;
    id_v = 16'b1010;
    pl_v = 16'b1001111;
    rep_v = 4'd2;
    start = 1'b1;
    @(negedge ref_clk);
    start = 1'b0;
    repeat (168) @(negedge ref_clk);
    chk("t6 busy pre", 32'(ia.busy), 32'd1);
    abort = 1'b1;
    @(negedge ref_clk);
    abort = 1'b0;
    chk("t6 aborted", 32'(ia.aborted), 32'd1);
    chk("t6 busy", 32'(ia.busy), 32'd0);
    chk("t6 out", 32'(ia.out), 32'd0);
    chk("t6 done", 32'(ia.done), 32'd0);
    start = 1'b1;
    @(negedge ref_clk);
    start = 1'b0;
    chk("t6 restart busy", 32'(ia.busy), 32'd1);
    chk("t6 aborted once", 32'(ia.aborted), 32'd0);
    reset = 1'b1;
    @(negedge ref_clk);
    reset = 1'b0;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
